// File: rtl/qs_chk_if.sv
// Beat stream from the sort engine into the checker, plus the checker's status and counters.
// The master modport drives the stream; the slave modport is the checker itself.
interface qs_chk_if #(
    parameter int W     = 32,
    parameter int N     = 64,
    parameter int CNT_W = 16
) ();
    localparam int LW = $clog2(N) + 1;

    logic             in_vld;
    logic             in_sop;
    logic             in_eop;
    logic             in_err;
    logic [W-1:0]     in_dat;
    logic             clr;

    logic             stat_vld_r;
    logic [LW-1:0]    stat_len_r;
    logic [3:0]       stat_code_r;
    logic [W-1:0]     stat_min_r;
    logic [W-1:0]     stat_max_r;
    logic [CNT_W-1:0] pkt_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;

    modport master (
        output in_vld, in_sop, in_eop, in_err, in_dat, clr,
        input  stat_vld_r, stat_len_r, stat_code_r, stat_min_r, stat_max_r,
               pkt_cnt_r, err_cnt_r
    );

    modport slave (
        input  in_vld, in_sop, in_eop, in_err, in_dat, clr,
        output stat_vld_r, stat_len_r, stat_code_r, stat_min_r, stat_max_r,
               pkt_cnt_r, err_cnt_r
    );
endinterface

// File: rtl/qs_chk.sv
// Sorted-stream checker: validates framing and ascending order of each packet, emits one
// registered status record per closed packet and keeps saturating packet/error counters.
//
//   state | meaning
//   IDLE  | no packet open; a non-sop beat is an orphan
//   BODY  | packet open; beats extend it, sop abandons it and restarts
module qs_chk #(
    parameter int W     = 32,
    parameter int N     = 64,
    parameter int CNT_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    qs_chk_if.slave   bus
);
    localparam int LW = $clog2(N) + 1;

    localparam int C_UPERR   = 0;
    localparam int C_ORDER   = 1;
    localparam int C_FRAME   = 2;
    localparam int C_OVERLEN = 3;

    typedef enum logic {IDLE, BODY} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     prev_q, prev_d;
    logic [W-1:0]     min_q, min_d;
    logic [W-1:0]     max_q, max_d;
    logic [LW-1:0]    len_q, len_d;
    logic [3:0]       code_q, code_d;

    logic             stat_vld_q, stat_vld_d;
    logic [LW-1:0]    stat_len_q, stat_len_d;
    logic [3:0]       stat_code_q, stat_code_d;
    logic [W-1:0]     stat_min_q, stat_min_d;
    logic [W-1:0]     stat_max_q, stat_max_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             close_pkt;
    logic [1:0]       err_inc;
    logic [CNT_W:0]   pkt_sum;
    logic [CNT_W:0]   err_sum;

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        min_d     = min_q;
        max_d     = max_q;
        len_d     = len_q;
        code_d    = code_q;
        close_pkt = 1'b0;
        err_inc   = 2'd0;

        if (bus.in_vld) begin
            if (bus.in_sop) begin
                // A sop while a packet is open abandons it silently and marks the restart.
                prev_d              = bus.in_dat;
                min_d               = bus.in_dat;
                max_d               = bus.in_dat;
                len_d               = LW'(1);
                code_d              = 4'b0000;
                code_d[C_UPERR]     = bus.in_err;
                code_d[C_FRAME]     = (state_q == BODY);
                if (state_q == BODY) begin
                    err_inc = 2'd1;
                end
                if (bus.in_eop) begin
                    close_pkt = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d   = BODY;
                end
            end else if (state_q == IDLE) begin
                err_inc = 2'd1;
            end else begin
                if (bus.in_dat < prev_q) begin
                    code_d[C_ORDER] = 1'b1;
                end
                if (bus.in_err) begin
                    code_d[C_UPERR] = 1'b1;
                end
                prev_d = bus.in_dat;
                if (bus.in_dat < min_q) begin
                    min_d = bus.in_dat;
                end
                if (bus.in_dat > max_q) begin
                    max_d = bus.in_dat;
                end
                if (len_q == LW'(N)) begin
                    code_d[C_OVERLEN] = 1'b1;
                end else begin
                    len_d = len_q + LW'(1);
                end
                if (bus.in_eop) begin
                    close_pkt = 1'b1;
                    state_d   = IDLE;
                end
            end
        end

        if (close_pkt && (code_d != 4'b0000)) begin
            err_inc = err_inc + 2'd1;
        end
    end

    always_comb begin
        stat_vld_d  = close_pkt;
        stat_len_d  = stat_len_q;
        stat_code_d = stat_code_q;
        stat_min_d  = stat_min_q;
        stat_max_d  = stat_max_q;
        if (close_pkt) begin
            stat_len_d  = len_d;
            stat_code_d = code_d;
            stat_min_d  = min_d;
            stat_max_d  = max_d;
        end

        // clr zeroes the base but keeps this cycle's increment; one spare bit catches saturation.
        pkt_sum = (bus.clr ? '0 : {1'b0, pkt_cnt_q}) + (CNT_W+1)'(close_pkt);
        err_sum = (bus.clr ? '0 : {1'b0, err_cnt_q}) + (CNT_W+1)'(err_inc);
        pkt_cnt_d = pkt_sum[CNT_W] ? {CNT_W{1'b1}} : pkt_sum[CNT_W-1:0];
        err_cnt_d = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            min_q       <= '0;
            max_q       <= '0;
            len_q       <= '0;
            code_q      <= '0;
            stat_vld_q  <= 1'b0;
            stat_len_q  <= '0;
            stat_code_q <= '0;
            stat_min_q  <= '0;
            stat_max_q  <= '0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            min_q       <= min_d;
            max_q       <= max_d;
            len_q       <= len_d;
            code_q      <= code_d;
            stat_vld_q  <= stat_vld_d;
            stat_len_q  <= stat_len_d;
            stat_code_q <= stat_code_d;
            stat_min_q  <= stat_min_d;
            stat_max_q  <= stat_max_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.stat_vld_r  = stat_vld_q;
    assign bus.stat_len_r  = stat_len_q;
    assign bus.stat_code_r = stat_code_q;
    assign bus.stat_min_r  = stat_min_q;
    assign bus.stat_max_r  = stat_max_q;
    assign bus.pkt_cnt_r   = pkt_cnt_q;
    assign bus.err_cnt_r   = err_cnt_q;
endmodule
